// File: rtl/arm_pkg.sv
// Shared register-file definitions for the ID-stage hazard logic.
package arm_pkg;

    localparam int REG_NUM = 16;
    localparam int REG_AW  = $clog2(REG_NUM);
    localparam int PC_IDX  = 15;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // True when the register index addresses the program counter.
    function automatic logic is_pc(input reg_idx_t r);
        return r == reg_idx_t'(PC_IDX);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
// Applies +inc -dec_a -dec_b atomically each cycle, saturating at the
// maximum and clamping at zero; ovf/udf flag the offending cycle.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             ovf,
    output logic             udf
);

    // Two guard bits hold the transient +1 above max.
    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             nz_reg;
    logic [SUM_W-1:0] up_sum;
    logic [SUM_W-1:0] dec_sum;
    logic [SUM_W-1:0] diff;

    // Net update: compare before subtracting so underflow never wraps.
    always_comb begin
        up_sum   = {2'b00, cnt_reg} + SUM_W'(inc);
        dec_sum  = SUM_W'(dec_a) + SUM_W'(dec_b);
        diff     = '0;
        cnt_next = cnt_reg;
        ovf      = 1'b0;
        udf      = 1'b0;
        if (up_sum < dec_sum) begin
            udf      = 1'b1;
            cnt_next = '0;
        end else begin
            diff = up_sum - dec_sum;
            if (diff > MAX_VAL) begin
                ovf      = 1'b1;
                cnt_next = MAX_VAL[CNT_W-1:0];
            end else begin
                cnt_next = diff[CNT_W-1:0];
            end
        end
    end

    // Counter and its registered non-zero flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            nz_reg  <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            nz_reg  <= (cnt_next != '0);
        end
    end

    assign cnt = cnt_reg;
    assign nz  = nz_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard beside the ID stage: counts in-flight writes per
// register from issue until writeback or flush, and stalls ID when a source
// operand still has an outstanding write.
module reg_scoreboard
    import arm_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1,
    parameter bit TRACK_PC  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  reg_idx_t           src1,
    input  reg_idx_t           src2,
    input  logic               two_src,
    input  logic               issue_valid,
    input  logic               issue_wb_en,
    input  reg_idx_t           issue_dest,
    input  logic               wb_valid,
    input  reg_idx_t           wb_dest,
    input  logic               cancel_valid,
    input  reg_idx_t           cancel_dest,
    output logic               stall,
    output logic [REG_NUM-1:0] busy_vec,
    output logic               err
);

    logic               inc;
    logic               dec_w;
    logic               dec_c;
    logic [REG_NUM-1:0] inc_vec;
    logic [REG_NUM-1:0] dec_w_vec;
    logic [REG_NUM-1:0] dec_c_vec;
    logic [REG_NUM-1:0] nz_vec;
    logic [REG_NUM-1:0] ovf_vec;
    logic [REG_NUM-1:0] udf_vec;
    logic [REG_NUM-1:0] hit_vec;
    logic [CNT_W-1:0]   cnt_arr [REG_NUM];
    logic               err_reg;

    // Event qualification; PC writes belong to the branch unit unless tracked.
    // A stalled issue is not advancing, so it must not count.
    assign inc   = issue_valid & issue_wb_en & ~stall & (TRACK_PC | ~is_pc(issue_dest));
    assign dec_w = wb_valid & (TRACK_PC | ~is_pc(wb_dest));
    assign dec_c = cancel_valid & (TRACK_PC | ~is_pc(cancel_dest));

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
            // One-hot decode of the three event ports for this register.
            assign inc_vec[gi]   = inc   & (issue_dest  == reg_idx_t'(gi));
            assign dec_w_vec[gi] = dec_w & (wb_dest     == reg_idx_t'(gi));
            assign dec_c_vec[gi] = dec_c & (cancel_dest == reg_idx_t'(gi));

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc_vec[gi]),
                .dec_a (dec_w_vec[gi]),
                .dec_b (dec_c_vec[gi]),
                .cnt   (cnt_arr[gi]),
                .nz    (nz_vec[gi]),
                .ovf   (ovf_vec[gi]),
                .udf   (udf_vec[gi])
            );

            // Hazard per register: the last pending write retiring this cycle
            // is visible through the RF write-through, so it does not stall.
            // A cancel carries no data and never hides a hazard.
            assign hit_vec[gi] = (TRACK_PC || (gi != PC_IDX))
                               & (cnt_arr[gi] != '0)
                               & ~(WB_BYPASS & dec_w_vec[gi] & (cnt_arr[gi] == CNT_W'(1)));
        end
    endgenerate

    // Stall depends only on source operands and retire state, never on issue.
    assign stall = hit_vec[src1] | (two_src & hit_vec[src2]);

    assign busy_vec = nz_vec;

    // Sticky error: any counter saturating or clamping sets it until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if ((|ovf_vec) || (|udf_vec)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus queues expected outputs per
// cycle, a monitor pops and compares them on the falling edge.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  src1 = '0, src2 = '0;
    logic        two_src = 1'b0;
    logic        issue_valid = 1'b0, issue_wb_en = 1'b0;
    logic [3:0]  issue_dest = '0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic        cancel_valid = 1'b0;
    logic [3:0]  cancel_dest = '0;
    logic        stall;
    logic [15:0] busy_vec;
    logic        err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic        stall;
        logic [15:0] busy;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    reg_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .issue_valid  (issue_valid),
        .issue_wb_en  (issue_wb_en),
        .issue_dest   (issue_dest),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .cancel_valid (cancel_valid),
        .cancel_dest  (cancel_dest),
        .stall        (stall),
        .busy_vec     (busy_vec),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that belongs to this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s stale: queued for cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else if (stall !== e.stall || busy_vec !== e.busy || err !== e.err) begin
                errors++;
                $display("FAIL %s: got stall=%0b busy=%04h err=%0b, want stall=%0b busy=%04h err=%0b",
                         e.name, stall, busy_vec, err, e.stall, e.busy, e.err);
            end else begin
                $display("ok   %s: stall=%0b busy=%04h err=%0b", e.name, stall, busy_vec, err);
            end
        end
    end

    task automatic expect_now(input string nm, input logic s, input logic [15:0] b, input logic e);
        exp_t x;
        x.cyc = cyc; x.name = nm; x.stall = s; x.busy = b; x.err = e;
        sb_q.push_back(x);
    endtask

    // Advance one cycle, then drive this cycle's inputs.
    task automatic step(input logic [3:0] s1, input logic [3:0] s2, input logic ts,
                        input logic iv, input logic iw, input logic [3:0] id,
                        input logic wv, input logic [3:0] wd,
                        input logic cv, input logic [3:0] cd);
        @(posedge clk);
        #1;
        src1 = s1; src2 = s2; two_src = ts;
        issue_valid = iv; issue_wb_en = iw; issue_dest = id;
        wb_valid = wv; wb_dest = wd;
        cancel_valid = cv; cancel_dest = cd;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Async assert mid-cycle, then release on the next cycle.
    task automatic pulse_reset(input string nm);
        @(posedge clk);
        #1;
        src1 = 0; src2 = 0; two_src = 0; issue_valid = 0; issue_wb_en = 0;
        issue_dest = 0; wb_valid = 0; wb_dest = 0; cancel_valid = 0; cancel_dest = 0;
        rst = 1'b0;
        #1;
        expect_now({nm, "_assert"}, 0, 16'h0000, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_now({nm, "_release"}, 0, 16'h0000, 0);
    endtask

    initial begin
        // 1: reset held with random inputs, then released.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            src1 = 4'($urandom_range(0, 15)); src2 = 4'($urandom_range(0, 15));
            two_src = 1'($urandom_range(0, 1));
            issue_valid = 1'($urandom_range(0, 1)); issue_wb_en = 1'($urandom_range(0, 1));
            issue_dest = 4'($urandom_range(0, 15));
            wb_valid = 1'($urandom_range(0, 1)); wb_dest = 4'($urandom_range(0, 15));
            cancel_valid = 1'($urandom_range(0, 1)); cancel_dest = 4'($urandom_range(0, 15));
            expect_now("rst_hold", 0, 16'h0000, 0);
        end
        idle(); rst = 1'b1; expect_now("rst_release", 0, 16'h0000, 0);
        idle(); expect_now("rst_after", 0, 16'h0000, 0);

        // 2: issue r4, read it next cycle, retire with bypass.
        step(0, 0, 0, 1, 1, 4, 0, 0, 0, 0); expect_now("t2_issue_r4", 0, 16'h0000, 0);
        step(4, 0, 0, 1, 1, 6, 0, 0, 0, 0); expect_now("t2_raw_stall", 1, 16'h0010, 0);
        step(4, 0, 0, 0, 0, 0, 1, 4, 0, 0); expect_now("t2_bypass", 0, 16'h0010, 0);
        step(4, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t2_retired", 0, 16'h0000, 0);
        // Issue without wb_en never marks a register busy.
        step(0, 0, 0, 1, 0, 9, 0, 0, 0, 0); expect_now("t2_no_wben", 0, 16'h0000, 0);
        step(9, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t2_no_wben_chk", 0, 16'h0000, 0);

        // 3: saturate r2 at 3, force a fourth issue, drain with three retires.
        step(0, 0, 0, 1, 1, 2, 0, 0, 0, 0); expect_now("t3_iss1", 0, 16'h0000, 0);
        step(0, 0, 0, 1, 1, 2, 0, 0, 0, 0); expect_now("t3_iss2", 0, 16'h0004, 0);
        step(0, 0, 0, 1, 1, 2, 0, 0, 0, 0); expect_now("t3_iss3", 0, 16'h0004, 0);
        step(0, 0, 0, 1, 1, 2, 0, 0, 0, 0); expect_now("t3_iss4", 0, 16'h0004, 0);
        step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t3_ovf_err", 1, 16'h0004, 1);
        step(2, 0, 0, 0, 0, 0, 1, 2, 0, 0); expect_now("t3_ret_cnt3", 1, 16'h0004, 1);
        step(2, 0, 0, 0, 0, 0, 1, 2, 0, 0); expect_now("t3_ret_cnt2", 1, 16'h0004, 1);
        step(2, 0, 0, 0, 0, 0, 1, 2, 0, 0); expect_now("t3_ret_cnt1", 0, 16'h0004, 1);
        step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t3_drained", 0, 16'h0000, 1);

        pulse_reset("t3_rst");

        // 4: issue+retire+cancel of r5 with counter 1 nets to 0, no error.
        step(0, 0, 0, 1, 1, 5, 0, 0, 0, 0); expect_now("t4_issue_r5", 0, 16'h0000, 0);
        step(5, 0, 0, 1, 1, 5, 1, 5, 1, 5); expect_now("t4_triple", 0, 16'h0020, 0);
        step(5, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t4_net_zero", 0, 16'h0000, 0);

        // 5: retire r7 at zero -> sticky error.
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0); expect_now("t5_udf", 0, 16'h0000, 0);
        step(7, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t5_err_set", 0, 16'h0000, 1);
        idle(); idle();                     expect_now("t5_err_sticky", 0, 16'h0000, 1);

        pulse_reset("t5_rst");

        // 6: PC writes ignored; two_src gating; cancel never bypasses.
        step(0, 0, 0, 1, 1, 15, 0, 0, 0, 0); expect_now("t6_issue_pc", 0, 16'h0000, 0);
        step(0, 15, 1, 0, 0, 0, 1, 15, 0, 0); expect_now("t6_src2_pc", 0, 16'h0000, 0);
        step(15, 0, 0, 1, 1, 4, 0, 0, 0, 0); expect_now("t6_pc_no_err", 0, 16'h0000, 0);
        step(0, 4, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t6_one_src", 0, 16'h0010, 0);
        step(0, 4, 1, 0, 0, 0, 0, 0, 0, 0); expect_now("t6_two_src", 1, 16'h0010, 0);
        step(4, 0, 0, 0, 0, 0, 0, 0, 1, 4); expect_now("t6_cancel", 1, 16'h0010, 0);
        step(4, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_now("t6_cancelled", 0, 16'h0000, 0);

        idle();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            errors += sb_q.size();
            checks += sb_q.size();
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
